// File: rtl/sync_event_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sync_evt_pkg
//
// Shared definitions for the asynchronous event arbiter:
//   ST_W      - width of the offer FSM state register
//   ST_IDLE   - no event offered; the picker is consulted every cycle
//   ST_OFFER  - an event is being offered and held until accepted
// ---------------------------------------------------------------------------
package sync_evt_pkg;

    localparam int ST_W = 1;

    localparam logic [ST_W-1:0] ST_IDLE  = 1'b0;
    localparam logic [ST_W-1:0] ST_OFFER = 1'b1;

endpackage : sync_evt_pkg

// File: rtl/sync_event_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker.
//   i_pend  - pending request vector
//   i_last  - channel granted most recently
//   o_any   - at least one request pending
//   o_chan  - first pending channel searching upward from i_last+1, wrapping
//             modulo NUM_CH (don't care when o_any is 0, driven to 0)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_pend,
    input  logic [CH_W-1:0]   i_last,
    output logic              o_any,
    output logic [CH_W-1:0]   o_chan
);

    logic w_found;

    always_comb begin
        w_found = 1'b0;
        o_chan  = '0;
        // Offset 1 first, offset NUM_CH (i_last itself) last, so the channel
        // that was just served has the lowest priority.
        for (int k = 1; k <= NUM_CH; k++) begin
            int w_idx;
            w_idx = int'(i_last) + k;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            if (!w_found && i_pend[w_idx]) begin
                o_chan  = CH_W'(w_idx);
                w_found = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule : rr_pick

// File: rtl/sync_event_arbiter_sync.sv
// ---------------------------------------------------------------------------
// sync_chain
//
// Multi-flop synchroniser for one asynchronous bit.
//   clock  - destination clock
//   i_rst  - synchronous active-high reset, clears the whole chain
//   i_d    - raw asynchronous input
//   o_q    - synchronised level, LEN clocks after i_d settles
// ---------------------------------------------------------------------------
module sync_chain #(
    parameter int LEN = 3
) (
    input  logic clock,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [LEN-1:0] r_chain;

    always_ff @(posedge clock) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[LEN-2:0], i_d};
        end
    end

    assign o_q = r_chain[LEN-1];

endmodule : sync_chain

// File: rtl/sync_event_arbiter.sv
// ---------------------------------------------------------------------------
// sync_event_arbiter
//
// Collects rising edges on NUM_CH asynchronous inputs and offers them, one at
// a time, on a single valid/ready port using round-robin arbitration.
//
// Ports:
//   clock      - single clock for the block
//   i_rst      - synchronous active-high reset
//   i_async    - raw asynchronous inputs
//   o_valid    - event offered downstream
//   i_ready    - downstream accepts the offered event
//   o_chan     - channel index of the offered event
//   o_sync     - synchronised input levels
//   o_ovf      - sticky per-channel overflow (edge merged into a pending one)
//   i_ovf_clr  - per-channel overflow clear
//
// Handshake: an event transfers on a clock edge where o_valid & i_ready. Once
// o_valid is raised, o_valid and o_chan stay constant until that transfer;
// only reset may withdraw an offer. i_ready reaches no output combinationally.
// ---------------------------------------------------------------------------
module sync_event_arbiter
    import sync_evt_pkg::*;
#(
    parameter  int NUM_CH       = 4,
    parameter  int SYNC_BUF_LEN = 3,
    localparam int CH_W         = $clog2(NUM_CH)
) (
    input  logic              clock,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_async,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CH_W-1:0]   o_chan,
    output logic [NUM_CH-1:0] o_sync,
    output logic [NUM_CH-1:0] o_ovf,
    input  logic [NUM_CH-1:0] i_ovf_clr
);

    logic [NUM_CH-1:0] w_sync;
    logic [NUM_CH-1:0] r_prev;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_ovf;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] w_ovf_set;

    logic [ST_W-1:0]   r_state;
    logic [CH_W-1:0]   r_last;
    logic              r_valid;
    logic [CH_W-1:0]   r_chan;

    logic              w_any;
    logic [CH_W-1:0]   w_pick;
    logic              w_hs;

    // -----------------------------------------------------------------------
    // Synchronisers, one per channel
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        sync_chain #(
            .LEN (SYNC_BUF_LEN)
        ) u_sync (
            .clock (clock),
            .i_rst (i_rst),
            .i_d   (i_async[g]),
            .o_q   (w_sync[g])
        );
    end

    // prev resets to 0 together with the chains, so an input held high across
    // reset produces exactly one rising edge once the chain refills.
    always_ff @(posedge clock) begin
        if (i_rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_sync;
        end
    end

    assign w_rise = w_sync & ~r_prev;

    // -----------------------------------------------------------------------
    // Pending and overflow flags
    // -----------------------------------------------------------------------
    assign w_hs  = r_valid & i_ready;
    assign w_clr = w_hs ? (NUM_CH'(1) << r_chan) : '0;

    // A rise on a channel whose pending event is leaving this cycle is a
    // fresh event, not an overflow.
    assign w_ovf_set = w_rise & r_pend & ~w_clr;

    always_ff @(posedge clock) begin
        if (i_rst) begin
            r_pend <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_rise;
            r_ovf  <= w_ovf_set | (r_ovf & ~i_ovf_clr);
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin selection and offer FSM
    // -----------------------------------------------------------------------
    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .i_pend (r_pend),
        .i_last (r_last),
        .o_any  (w_any),
        .o_chan (w_pick)
    );

    always_ff @(posedge clock) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_chan  <= '0;
            r_last  <= CH_W'(NUM_CH - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_chan  <= w_pick;
                        r_valid <= 1'b1;
                        r_state <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    // Non-preemptive: the offered channel is held regardless
                    // of what becomes pending meanwhile.
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= r_chan;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_chan  = r_chan;
    assign o_sync  = w_sync;
    assign o_ovf   = r_ovf;

endmodule : sync_event_arbiter

// File: tb/tb_sync_event_arbiter.sv
module tb_sync_event_arbiter;

  localparam int NUM_CH = 4;
  localparam int SYNC_BUF_LEN = 3;
  localparam int CH_W = 2;

  // clock / reset
  logic clock = 1'b0;
  logic i_rst = 1'b1;
  logic [NUM_CH-1:0] i_async = '0;
  logic i_ready = 1'b0;
  logic [NUM_CH-1:0] i_ovf_clr = '0;
  logic o_valid;
  logic [CH_W-1:0] o_chan;
  logic [NUM_CH-1:0] o_sync;
  logic [NUM_CH-1:0] o_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sync_event_arbiter #(
    .NUM_CH       (NUM_CH),
    .SYNC_BUF_LEN (SYNC_BUF_LEN)
  ) dut (
    .clock     (clock),
    .i_rst     (i_rst),
    .i_async   (i_async),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_chan    (o_chan),
    .o_sync    (o_sync),
    .o_ovf     (o_ovf),
    .i_ovf_clr (i_ovf_clr)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish (got timeout, want completion)");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change 1 time unit after a rising edge, outputs are
  // sampled at that same point (well clear of the edge)
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_async = '0;
    i_ovf_clr = '0;
    step(2);
    i_rst = 1'b0;
    step(1);
  endtask

  // count cycles with o_valid high over n cycles
  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (o_valid) cnt++;
    end
  endtask

  // expect an offer on chan at this sample, then acceptance (ready=1)
  task automatic expect_grant(input string tag, input logic [CH_W-1:0] ch);
    check_val({tag, "_valid"}, 32'(o_valid), 32'd1);
    check_val({tag, "_chan"}, 32'(o_chan), 32'(ch));
  endtask

  initial begin
    int cnt;
    int bad;

    // ---------------- reset state
    i_rst = 1'b1;
    step(2);
    check_val("rst_valid", 32'(o_valid), 32'd0);
    check_val("rst_chan", 32'(o_chan), 32'd0);
    check_val("rst_ovf", 32'(o_ovf), 32'd0);
    check_val("rst_sync", 32'(o_sync), 32'd0);
    i_rst = 1'b0;
    step(2);

    // ---------------- single event on channel 2, 5-edge latency
    i_ready = 1'b1;
    i_async = 4'b0100;
    step(3);
    check_val("single_sync", 32'(o_sync), 32'h4);
    step(1);
    check_val("single_early", 32'(o_valid), 32'd0);
    step(1);
    expect_grant("single", 2'd2);
    step(1);
    check_val("single_drop", 32'(o_valid), 32'd0);
    count_valid(10, cnt);
    check_val("single_held_noevt", 32'(cnt), 32'd0);
    i_async = '0;
    step(5);

    // ---------------- simultaneous rises on 0,1,3 after reset
    do_reset();
    i_ready = 1'b1;
    i_async = 4'b1011;
    step(4);
    check_val("multi_early", 32'(o_valid), 32'd0);
    step(1);
    expect_grant("multi_g0", 2'd0);
    step(1);
    check_val("multi_gap0", 32'(o_valid), 32'd0);
    step(1);
    expect_grant("multi_g1", 2'd1);
    step(1);
    check_val("multi_gap1", 32'(o_valid), 32'd0);
    step(1);
    expect_grant("multi_g3", 2'd3);
    step(1);
    check_val("multi_end", 32'(o_valid), 32'd0);
    check_val("multi_ovf", 32'(o_ovf), 32'd0);
    i_async = '0;
    step(5);

    // ---------------- fairness: last grant 1, pend {0,2} -> 2 before 0
    do_reset();
    i_ready = 1'b0;
    i_async = 4'b0010;
    step(5);
    expect_grant("fair_g1", 2'd1);
    i_async = 4'b0111;
    step(4);
    i_ready = 1'b1;
    step(1);
    check_val("fair_gap", 32'(o_valid), 32'd0);
    step(1);
    expect_grant("fair_g2", 2'd2);
    step(2);
    expect_grant("fair_g0", 2'd0);
    step(1);
    check_val("fair_end", 32'(o_valid), 32'd0);
    i_async = '0;
    step(5);

    // ---------------- backpressure and overflow on channel 3
    do_reset();
    i_ready = 1'b0;
    i_async = 4'b1000;
    step(5);
    expect_grant("bp_offer", 2'd3);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (o_valid !== 1'b1 || o_chan !== 2'd3) bad++;
    end
    check_val("bp_stable", 32'(bad), 32'd0);
    i_async = 4'b0000;
    step(4);
    i_async = 4'b1000;
    step(3);
    check_val("bp_ovf_pre", 32'(o_ovf), 32'd0);
    step(1);
    check_val("bp_ovf_set", 32'(o_ovf), 32'h8);
    expect_grant("bp_still", 2'd3);
    i_ovf_clr = 4'b1000;
    step(1);
    i_ovf_clr = 4'b0000;
    check_val("bp_ovf_clr", 32'(o_ovf), 32'd0);
    i_ready = 1'b1;
    step(1);
    check_val("bp_consume", 32'(o_valid), 32'd0);
    count_valid(10, cnt);
    check_val("bp_merged", 32'(cnt), 32'd0);
    i_async = '0;
    step(5);

    // ---------------- input high through reset
    i_rst = 1'b1;
    i_async = 4'b0001;
    i_ready = 1'b1;
    step(3);
    check_val("rh_sync_in_rst", 32'(o_sync), 32'd0);
    i_rst = 1'b0;
    step(4);
    check_val("rh_early", 32'(o_valid), 32'd0);
    step(1);
    expect_grant("rh_g0", 2'd0);
    count_valid(10, cnt);
    check_val("rh_once", 32'(cnt), 32'd0);
    i_async = '0;
    step(5);

    // ---------------- reset while offering, pend {1,2}, ovf[1]
    do_reset();
    i_ready = 1'b0;
    i_async = 4'b0010;
    step(5);
    expect_grant("mr_offer", 2'd1);
    i_async = 4'b0100;
    step(4);
    i_async = 4'b0110;
    step(4);
    check_val("mr_ovf_pre", 32'(o_ovf), 32'h2);
    i_async = '0;
    i_rst = 1'b1;
    step(1);
    check_val("mr_valid", 32'(o_valid), 32'd0);
    check_val("mr_ovf", 32'(o_ovf), 32'd0);
    step(1);
    i_rst = 1'b0;
    i_ready = 1'b1;
    count_valid(12, cnt);
    check_val("mr_no_stale", 32'(cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
